// File: rtl/dec4to10_strobe.sv
`default_nettype none
// ============================================================================
// Module   : dec4to10_strobe
// Purpose  : Registered 4-to-10 decoder; each accepted decimal code becomes a
//            timed active-low strobe on one of ten lines, then an all-high gap.
// Revision : 1.0  initial release
// ============================================================================
module dec4to10_strobe #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] F,
    input  logic       valid,
    output logic       in_ready,
    output logic [9:0] Y,
    output logic       busy,
    output logic       err,
    output logic [3:0] last_code,
    output logic [7:0] code_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ASSERT = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    localparam logic [9:0] c_all_high  = 10'h3FF;
    localparam logic [7:0] c_pulse_ld  = 8'(PULSE_CYCLES - 1);
    // Only meaningful when a gap exists; unused when GAP_CYCLES is zero.
    localparam logic [7:0] c_gap_ld    = 8'(GAP_CYCLES - 1);
    localparam logic       c_has_gap   = (GAP_CYCLES > 0);

    logic [1:0] r_state;
    logic [7:0] r_count;
    logic [9:0] r_y;
    logic       r_err;
    logic [3:0] r_last_code;
    logic [7:0] r_code_cnt;

    logic       w_accept;

    assign w_accept = valid && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= 8'd0;
            r_y         <= c_all_high;
            r_err       <= 1'b0;
            r_last_code <= 4'd0;
            r_code_cnt  <= 8'd0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (F <= 4'd9) begin
                            r_y         <= ~(10'd1 << F);
                            r_last_code <= F;
                            r_code_cnt  <= r_code_cnt + 8'd1;
                            r_count     <= c_pulse_ld;
                            r_state     <= S_ASSERT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ASSERT: begin
                    if (r_count != 8'd0) begin
                        r_count <= r_count - 8'd1;
                    end else begin
                        r_y <= c_all_high;
                        if (c_has_gap) begin
                            r_count <= c_gap_ld;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (r_count != 8'd0) begin
                        r_count <= r_count - 8'd1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= 8'd0;
                    r_y     <= c_all_high;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign Y         = r_y;
    assign err       = r_err;
    assign last_code = r_last_code;
    assign code_cnt  = r_code_cnt;

endmodule
`default_nettype wire

// File: doc/dec4to10_strobe.md
Name: dec4to10_strobe

Overview:
- Registered 4-to-10 decoder; the receiving end of the 10-to-4 priority encoder path.
- Accepts a 4-bit decimal code plus valid through a ready/valid handshake.
- Regenerates the matching active-low one-of-ten line as a timed strobe, followed by an all-high gap.
- Rejects codes 10–15 with an error pulse and keeps a sticky last-code and an accepted-code count for debug.

Parameters:
PULSE_CYCLES, 4, cycles the selected output line is held low (legal range 1–255)
GAP_CYCLES, 1, cycles all outputs are held high after a strobe before the next code is accepted (legal range 0–255)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous reset, active-high
F  input  4  decimal code, 0–9 legal
valid  input  1  F is meaningful this cycle
in_ready  output  1  block can accept a code this cycle
Y  output  10  active-low one-of-ten lines; Y[k]=0 selects digit k; 10'h3FF means no line
busy  output  1  strobe or gap in progress
err  output  1  one-cycle pulse: an illegal code (10–15) was accepted
last_code  output  4  most recent legal code accepted
code_cnt  output  8  number of legal codes accepted, wraps 255→0

Behaviour:
- One clock domain. All state changes on the rising clk edge. rst is sampled only on the clock edge.
- Reset values: Y=10'h3FF, err=0, last_code=0, code_cnt=0, state=IDLE, counter=0. in_ready=1 and busy=0 follow from IDLE.
- in_ready=(state==IDLE), combinational from state. busy=(state!=IDLE). All other outputs are registered.
- Accept = valid && in_ready at a clock edge. When valid=1 and in_ready=0, the code is ignored, not queued. The source must hold valid until it sees in_ready.
- State machine IDLE / ASSERT / GAP:
  - IDLE, accept, F≤9:
    - Y ← all ones except bit F=0.
    - last_code ← F; code_cnt ← code_cnt+1 (mod 256).
    - counter ← PULSE_CYCLES−1; go to ASSERT.
  - IDLE, accept, F≥10:
    - err ← 1 for exactly one cycle; Y unchanged (3FF).
    - last_code and code_cnt unchanged; stay in IDLE, so in_ready stays 1.
  - ASSERT:
    - counter>0: decrement; Y held.
    - counter==0: Y ← 3FF. If GAP_CYCLES>0, counter ← GAP_CYCLES−1 and go to GAP; otherwise go to IDLE.
  - GAP: counter>0 decrements; counter==0 goes to IDLE.
- Timing:
  - Accept at edge N → Y low during cycles N+1 … N+PULSE_CYCLES.
  - Y back to 3FF from cycle N+PULSE_CYCLES+1.
  - in_ready returns at cycle N+1+PULSE_CYCLES+GAP_CYCLES.
  - Defaults (PULSE=4, GAP=1): the next accept is possible at edge N+6.
- err is cleared on every edge where no illegal code is accepted. It never coincides with a strobe start.
- Y has at most one bit low at any time. Y is never low while in GAP or IDLE.
- Counter width is 8 bits, sufficient for both parameter ranges.
- rst during ASSERT or GAP: on the next edge, all state and outputs take their reset values. The strobe is truncated with no gap, and last_code and code_cnt are cleared.
- rst together with valid: rst wins and the code is not accepted.
- Code 0 is a legal strobe on Y[0]. It is distinct from "no input", which is carried by valid=0.

Test Plan:
- Reset, then F=7, valid=1 for 1 cycle (defaults) → Y=10'h37F for 4 cycles, then 3FF. in_ready low for 5 cycles. last_code=7, code_cnt=1.
- Sweep F=0…9 back-to-back, holding valid=1 → each code accepted every 6 cycles; Y[k] low in sequence; code_cnt=10; err never high.
- F=12, valid=1 in IDLE → err=1 for exactly 1 cycle; Y stays 3FF; in_ready stays 1; last_code and code_cnt unchanged.
- F=3 accepted, then F=5 presented during ASSERT → F=5 ignored until in_ready returns. It is accepted only if valid is still high then; Y[3] never overlaps Y[5].
- PULSE_CYCLES=1, GAP_CYCLES=0, F=9 → Y=10'h1FF for 1 cycle; in_ready back after 1 cycle, so one strobe every 2 cycles.
- rst asserted in the 2nd ASSERT cycle of F=2 → next cycle Y=3FF, in_ready=1, code_cnt=0, last_code=0. Then accept 256 legal codes → code_cnt wraps to 0.
